// File: rtl/mag_sq_seq.sv
// Shift-add sum of squares x = a^2 + b^2, one partial product per clock.
// Define MAG_SQ_ZERO_SKIP_EN to bypass the squaring phase of a zero operand.
module mag_sq_seq #(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*W-1:0]      x_out,
  output logic                busy
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQ_A = 2'd1,
    SQ_B = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q;
  logic [W-1:0]     ma_q;
  logic [W-1:0]     mb_q;
  logic [2*W-1:0]   acc_q;
  logic [CW-1:0]    cnt_q;
  logic [2*W-1:0]   x_q;
  logic             ov_q;

  logic [W-1:0]     ma_d;
  logic [W-1:0]     mb_d;
  logic [W-1:0]     cur;
  logic [2*W-1:0]   part;
  logic [2*W-1:0]   acc_d;
  logic             last;

  // Most negative input maps to 2^(W-1), still exact as unsigned W bits.
  function automatic logic [W-1:0] mag(input logic signed [W-1:0] v);
    logic [W-1:0] u;
    u = v;
    return v[W-1] ? (~u + {{(W-1){1'b0}}, 1'b1}) : u;
  endfunction

  always_comb begin
    ma_d  = mag(a);
    mb_d  = mag(b);
    cur   = (state_q == SQ_B) ? mb_q : ma_q;
    part  = '0;
    if (cur[cnt_q])
      part = {{W{1'b0}}, cur} << cnt_q;
    acc_d = acc_q + part;
    last  = (cnt_q == LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ma_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      ov_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            acc_q   <= '0;
            cnt_q   <= '0;
`ifdef MAG_SQ_ZERO_SKIP_EN
            if (ma_d == '0 && mb_d == '0) begin
              x_q     <= '0;
              ov_q    <= 1'b1;
              state_q <= DONE;
            end else if (ma_d == '0) begin
              state_q <= SQ_B;
            end else begin
              state_q <= SQ_A;
            end
`else
            state_q <= SQ_A;
`endif
          end
        end
        SQ_A: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + ONE;
          if (last) begin
            cnt_q <= '0;
`ifdef MAG_SQ_ZERO_SKIP_EN
            if (mb_q == '0) begin
              x_q     <= acc_d;
              ov_q    <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= SQ_B;
            end
`else
            state_q <= SQ_B;
`endif
          end
        end
        SQ_B: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + ONE;
          if (last) begin
            cnt_q   <= '0;
            x_q     <= acc_d;
            ov_q    <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            ov_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = ov_q;
  assign x_out     = x_q;

endmodule

// File: tb/tb_mag_sq_seq.sv
// Self-checking bench for mag_sq_seq: directed table, corner sequences,
// and randomized handshake traffic against an arithmetic reference.
module tb_mag_sq_seq;

  localparam int W = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                out_ready;
  logic signed [W-1:0] a;
  logic signed [W-1:0] b;
  logic                in_ready;
  logic                out_valid;
  logic                busy;
  logic [2*W-1:0]      x_out;

  int checks = 0;
  int errors = 0;

  mag_sq_seq #(.W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .x_out    (x_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] a;
    logic signed [15:0] b;
    logic [31:0]        x;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_sq(input logic signed [15:0] p,
                                           input logic signed [15:0] q);
    longint s;
    s = longint'(p) * longint'(p) + longint'(q) * longint'(q);
    return s[31:0];
  endfunction

  // Clock edges after the accept edge until out_valid is visible.
  function automatic int edges_to_valid(input logic signed [15:0] p,
                                        input logic signed [15:0] q);
`ifdef MAG_SQ_ZERO_SKIP_EN
    if (p == 0 && q == 0) return 0;
    if (p == 0 || q == 0) return W;
    return 2 * W;
`else
    return 2 * W;
`endif
  endfunction

  function automatic logic signed [15:0] rand_op();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return 16'sd0;
    if (sel == 1) return -16'sd32768;
    if (sel == 2) return 16'sd32767;
    return 16'($urandom);
  endfunction

  task automatic run_pair(input logic signed [15:0] va,
                          input logic signed [15:0] vb,
                          output logic [31:0] xr, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
    a = va;
    b = vb;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) chk("result_timeout", 64'(out_valid), 64'd1);
    xr = x_out;
  endtask

  logic [31:0] xr;
  int          lat;
  logic [31:0] q[$];
  int          sent;
  int          rcvd;
  int          cyc;

  initial begin
    vecs[0] = '{16'sd3, 16'sd4, 32'd25};
    vecs[1] = '{-16'sd32768, -16'sd32768, 32'h8000_0000};
    vecs[2] = '{-16'sd1, 16'sd32767, 32'h3FFF_0002};
    vecs[3] = '{16'sd0, 16'sd5, 32'd25};
    vecs[4] = '{16'sd0, 16'sd0, 32'd0};
    vecs[5] = '{16'sd7, 16'sd0, 32'd49};
    vecs[6] = '{16'sd32767, 16'sd32767, 32'h7FFE_0002};

    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_x_out", 64'(x_out), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      run_pair(vecs[i].a, vecs[i].b, xr, lat);
      chk("vec_x", 64'(xr), 64'(vecs[i].x));
      chk("vec_lat", 64'(lat), 64'(edges_to_valid(vecs[i].a, vecs[i].b)));
      @(posedge clk); #1;
      chk("vec_consumed", 64'(out_valid), 64'd0);
      chk("vec_ready_after", 64'(in_ready), 64'd1);
    end

    out_ready = 1'b0;
    run_pair(16'sd5, 16'sd12, xr, lat);
    chk("hold_x", 64'(xr), 64'd169);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      a = 16'sd1;
      b = 16'sd1;
      @(posedge clk); #1;
      chk("hold_x_stable", 64'(x_out), 64'd169);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_not_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_consumed", 64'(out_valid), 64'd0);
    chk("hold_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold_no_dup", 64'(out_valid), 64'd0);
      chk("hold_idle", 64'(busy), 64'd0);
    end

    a = 16'sd7;
    b = 16'sd9;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_x_out", 64'(x_out), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    run_pair(16'sd6, 16'sd8, xr, lat);
    chk("post_rst_x", 64'(xr), 64'd100);
    chk("post_rst_lat", 64'(lat), 64'(2 * W));
    @(posedge clk); #1;
    chk("post_rst_consumed", 64'(out_valid), 64'd0);

    sent = 0;
    rcvd = 0;
    cyc = 0;
    while ((sent < 200 || rcvd < sent) && cyc < 20000) begin
      in_valid  = (sent < 200) && ($urandom_range(0, 3) != 0);
      a         = rand_op();
      b         = rand_op();
      out_ready = 1'($urandom_range(0, 1));
      if (in_valid && in_ready) begin
        q.push_back(model_sq(a, b));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rand_spurious", 64'(x_out), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          chk("rand_x", 64'(x_out), 64'(q.pop_front()));
        end
        rcvd++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("rand_sent", 64'(sent), 64'd200);
    chk("rand_rcvd", 64'(rcvd), 64'd200);
    chk("rand_queue_empty", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
